// File: rtl/armleocpu_regfile_sb_pkg.sv
// Shared limits and address helpers for the scoreboarded register file.
package armleocpu_regfile_sb_pkg;

    localparam int unsigned MIN_REG_COUNT  = 2;
    localparam int unsigned MAX_REG_COUNT  = 64;
    localparam int unsigned MIN_READ_PORTS = 1;
    localparam int unsigned MAX_READ_PORTS = 4;

    // True when the address names real, writable storage (excludes hardwired x0 and holes).
    function automatic logic addr_writable(
        input int unsigned addr,
        input int unsigned reg_count,
        input logic        zero_reg
    );
        return (addr < reg_count) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/armleocpu_regfile_scoreboard.sv
// Busy-bit scoreboard: tracks destinations with results still in flight.
module armleocpu_regfile_scoreboard
    import armleocpu_regfile_sb_pkg::*;
#(
    parameter int unsigned REG_COUNT = 32,
    parameter bit          ZERO_REG  = 1'b1,
    parameter int unsigned ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_addr,
    output logic                 issue_ready_c,
    input  logic                 wb_valid,
    input  logic [ADDR_W-1:0]    wb_addr,
    input  logic                 flush,
    output logic [REG_COUNT-1:0] busy,
    output logic [ADDR_W:0]      busy_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic                 issue_writable;
    logic                 wb_writable;
    logic                 wb_hits_issue;
    logic                 issue_fire;
    logic [REG_COUNT-1:0] busy_nxt;
    logic [CNT_W-1:0]     count_nxt;

    // A pending destination stalls a new reservation unless it retires this very cycle.
    always_comb begin
        issue_writable = addr_writable(32'(issue_addr), REG_COUNT, ZERO_REG);
        wb_writable    = addr_writable(32'(wb_addr), REG_COUNT, ZERO_REG);
        wb_hits_issue  = wb_valid && (wb_addr == issue_addr);
        issue_ready_c  = rst_n && !(issue_writable && busy[issue_addr] && !wb_hits_issue);
    end

    // Next busy vector: flush beats everything, a same-cycle reservation beats the retiring write.
    always_comb begin
        busy_nxt   = busy;
        count_nxt  = '0;
        issue_fire = issue_valid && issue_ready_c && issue_writable;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wb_valid && wb_writable) begin
                busy_nxt[wb_addr] = 1'b0;
            end
            if (issue_fire) begin
                busy_nxt[issue_addr] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            count_nxt = count_nxt + CNT_W'(busy_nxt[i]);
        end
    end

    // Busy bits and their population count move together on the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= count_nxt;
        end
    end

endmodule

// File: rtl/armleocpu_regfile_sb.sv
// Parametrised integer register file with busy scoreboard and writeback bypass.
module armleocpu_regfile_sb
    import armleocpu_regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned READ_PORTS = 2,
    parameter bit          ZERO_REG   = 1'b1,
    parameter int unsigned ADDR_W     = $clog2(REG_COUNT)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [READ_PORTS*ADDR_W-1:0] rs_addr,
    output logic [READ_PORTS*XLEN-1:0]   rs_rdata,
    output logic [READ_PORTS-1:0]        rs_busy,
    input  logic                         issue_valid,
    input  logic [ADDR_W-1:0]            issue_addr,
    output logic                         issue_ready,
    input  logic                         wb_valid,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [XLEN-1:0]              wb_data,
    input  logic                         flush,
    output logic [ADDR_W:0]              busy_count
);

    logic [XLEN-1:0]      regs [REG_COUNT];
    logic [REG_COUNT-1:0] busy;
    logic                 issue_ready_c;
    logic                 wb_writable;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_writable;
    logic                 rd_hits_wb;

    armleocpu_regfile_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .ZERO_REG  (ZERO_REG),
        .ADDR_W    (ADDR_W)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_addr    (issue_addr),
        .issue_ready_c (issue_ready_c),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .flush         (flush),
        .busy          (busy),
        .busy_count    (busy_count)
    );

    // Reservation handshake comes straight from the scoreboard.
    always_comb begin
        issue_ready = issue_ready_c;
        wb_writable = addr_writable(32'(wb_addr), REG_COUNT, ZERO_REG);
    end

    // Register storage; x0 and unmapped addresses never take a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid && wb_writable) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Per-port operand mux: bypass the retiring value, mask hardwired/unmapped addresses to 0.
    always_comb begin
        rs_rdata    = '0;
        rs_busy     = '0;
        rd_addr     = '0;
        rd_writable = 1'b0;
        rd_hits_wb  = 1'b0;
        for (int unsigned i = 0; i < READ_PORTS; i++) begin
            rd_addr     = rs_addr[i*ADDR_W +: ADDR_W];
            rd_writable = addr_writable(32'(rd_addr), REG_COUNT, ZERO_REG);
            rd_hits_wb  = rst_n && wb_valid && (wb_addr == rd_addr);
            if (rd_writable) begin
                rs_rdata[i*XLEN +: XLEN] = rd_hits_wb ? wb_data : regs[rd_addr];
                rs_busy[i]               = busy[rd_addr] && !rd_hits_wb;
            end
        end
    end

endmodule

// File: tb/tb_armleocpu_regfile_sb.sv
// Bench for armleocpu_regfile_sb: directed scenarios plus random traffic against an array model.
module tb_armleocpu_regfile_sb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RC    = 20;
    localparam int unsigned RP    = 4;
    localparam int unsigned AW    = $clog2(RC);
    localparam int unsigned NSLOT = 1 << AW;

    logic              clk         = 1'b0;
    logic              rst_n       = 1'b0;
    logic [RP*AW-1:0]  rs_addr     = '0;
    logic [RP*XLEN-1:0] rs_rdata;
    logic [RP-1:0]     rs_busy;
    logic              issue_valid = 1'b0;
    logic [AW-1:0]     issue_addr  = '0;
    logic              issue_ready;
    logic              wb_valid    = 1'b0;
    logic [AW-1:0]     wb_addr     = '0;
    logic [XLEN-1:0]   wb_data     = '0;
    logic              flush       = 1'b0;
    logic [AW:0]       busy_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [XLEN-1:0] m_regs [RC];
    bit              m_busy [RC];

    armleocpu_regfile_sb #(
        .XLEN       (XLEN),
        .REG_COUNT  (RC),
        .READ_PORTS (RP),
        .ZERO_REG   (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs_addr     (rs_addr),
        .rs_rdata    (rs_rdata),
        .rs_busy     (rs_busy),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush),
        .busy_count  (busy_count)
    );

    always #5 clk = ~clk;

    function automatic bit wr_ok(input int unsigned a);
        return (a < RC) && (a != 0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: compare the DUT against architectural rules, then apply this cycle's edge to the model.
    always @(negedge clk) begin
        int unsigned     a;
        int unsigned     ia;
        int unsigned     wa;
        int unsigned     cnt;
        bit              hit;
        bit              e_busy;
        bit              e_ready;
        logic [XLEN-1:0] e_data;
        if (!rst_n) begin
            for (int i = 0; i < RC; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end
        for (int p = 0; p < RP; p++) begin
            a      = 32'(rs_addr[p*AW +: AW]);
            hit    = wb_valid && (32'(wb_addr) == a);
            e_data = '0;
            e_busy = 1'b0;
            if (rst_n && wr_ok(a)) begin
                e_data = hit ? wb_data : m_regs[a];
                e_busy = m_busy[a] && !hit;
            end
            check($sformatf("rdata[%0d] addr %0d", p, a), 64'(rs_rdata[p*XLEN +: XLEN]), 64'(e_data));
            check($sformatf("rs_busy[%0d] addr %0d", p, a), 64'(rs_busy[p]), 64'(e_busy));
        end
        ia      = 32'(issue_addr);
        wa      = 32'(wb_addr);
        e_ready = rst_n && !(wr_ok(ia) && m_busy[ia] && !(wb_valid && wa == ia));
        check("issue_ready", 64'(issue_ready), 64'(e_ready));
        cnt = 0;
        for (int i = 0; i < RC; i++) cnt += m_busy[i] ? 1 : 0;
        check("busy_count", 64'(busy_count), 64'(cnt));
        if (rst_n) begin
            if (wb_valid && wr_ok(wa)) m_regs[wa] = wb_data;
            if (flush) begin
                for (int i = 0; i < RC; i++) m_busy[i] = 1'b0;
            end else begin
                if (wb_valid && wr_ok(wa)) m_busy[wa] = 1'b0;
                if (issue_valid && e_ready && wr_ok(ia)) m_busy[ia] = 1'b1;
            end
        end
    end

    task automatic drive(input bit iv, input int unsigned ia, input bit wv,
                         input int unsigned wa, input logic [XLEN-1:0] wd, input bit fl);
        issue_valid = iv;
        issue_addr  = AW'(ia);
        wb_valid    = wv;
        wb_addr     = AW'(wa);
        wb_data     = wd;
        flush       = fl;
    endtask

    task automatic set_rs(input int unsigned a0, input int unsigned a1,
                          input int unsigned a2, input int unsigned a3);
        rs_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset: outputs forced quiet even with a writeback presented
        drive(1, 3, 1, 3, 32'h0000FFFF, 0);
        set_rs(3, 0, 0, 0);
        at_neg();
        check("reset rdata0", 64'(rs_rdata[0 +: XLEN]), 64'h0);
        check("reset ready", 64'(issue_ready), 64'h0);
        check("reset count", 64'(busy_count), 64'h0);
        next_cycle();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, '0, 0);

        // Sweep every address, including unmapped ones
        for (int a = 0; a < NSLOT; a += 4) begin
            next_cycle();
            set_rs(a, a + 1, a + 2, a + 3);
            at_neg();
            for (int p = 0; p < RP; p++) begin
                check("sweep rdata", 64'(rs_rdata[p*XLEN +: XLEN]), 64'h0);
                check("sweep busy", 64'(rs_busy[p]), 64'h0);
            end
            check("sweep ready", 64'(issue_ready), 64'h1);
        end

        // Reserve x5, observe busy, retire with bypass
        next_cycle(); drive(1, 5, 0, 0, '0, 0); set_rs(0, 0, 0, 0);
        at_neg(); check("x5 issue ready", 64'(issue_ready), 64'h1);
        next_cycle(); drive(0, 0, 0, 0, '0, 0); set_rs(5, 0, 0, 0);
        at_neg(); check("x5 busy", 64'(rs_busy[0]), 64'h1); check("x5 count", 64'(busy_count), 64'h1);
        next_cycle(); drive(0, 0, 1, 5, 32'hDEADBEEF, 0);
        at_neg(); check("x5 bypass", 64'(rs_rdata[0 +: XLEN]), 64'hDEADBEEF); check("x5 bypass busy", 64'(rs_busy[0]), 64'h0);
        next_cycle(); drive(0, 0, 0, 0, '0, 0);
        at_neg(); check("x5 count after wb", 64'(busy_count), 64'h0); check("x5 stored", 64'(rs_rdata[0 +: XLEN]), 64'hDEADBEEF);

        // WAW stall on x7, then release by same-cycle writeback
        next_cycle(); drive(1, 7, 0, 0, '0, 0);
        next_cycle(); drive(1, 7, 0, 0, '0, 0); set_rs(7, 0, 0, 0);
        at_neg(); check("x7 stall", 64'(issue_ready), 64'h0); check("x7 stall count", 64'(busy_count), 64'h1);
        next_cycle(); drive(1, 7, 1, 7, 32'h00000077, 0);
        at_neg(); check("x7 wb releases", 64'(issue_ready), 64'h1);
        next_cycle(); drive(0, 0, 0, 0, '0, 0);
        at_neg(); check("x7 still busy", 64'(rs_busy[0]), 64'h1); check("x7 count", 64'(busy_count), 64'h1);
        check("x7 data", 64'(rs_rdata[0 +: XLEN]), 64'h77);
        next_cycle(); drive(0, 0, 1, 7, 32'h00000070, 0);
        next_cycle(); drive(0, 0, 0, 0, '0, 0);
        at_neg(); check("x7 cleared", 64'(busy_count), 64'h0);

        // x0 is hardwired
        next_cycle(); drive(1, 0, 1, 0, 32'h12345678, 0); set_rs(0, 0, 0, 0);
        at_neg(); check("x0 ready", 64'(issue_ready), 64'h1); check("x0 bypass", 64'(rs_rdata[0 +: XLEN]), 64'h0);
        next_cycle(); drive(0, 0, 0, 0, '0, 0);
        at_neg(); check("x0 read", 64'(rs_rdata[0 +: XLEN]), 64'h0); check("x0 busy", 64'(rs_busy[0]), 64'h0);
        check("x0 count", 64'(busy_count), 64'h0);

        // Flush with concurrent writeback and issue
        next_cycle(); drive(1, 3, 0, 0, '0, 0);
        next_cycle(); drive(1, 4, 0, 0, '0, 0);
        next_cycle(); drive(1, 9, 0, 0, '0, 0);
        next_cycle(); drive(1, 10, 1, 4, 32'hA5A5A5A5, 1);
        at_neg(); check("pre-flush count", 64'(busy_count), 64'h3);
        next_cycle(); drive(0, 0, 0, 0, '0, 0); set_rs(4, 10, 3, 9);
        at_neg(); check("flush count", 64'(busy_count), 64'h0);
        check("flush x4 data", 64'(rs_rdata[0 +: XLEN]), 64'hA5A5A5A5);
        check("flush x10 busy", 64'(rs_busy[1]), 64'h0);

        // Four ports, unmapped address
        for (int k = 1; k <= 4; k++) begin
            next_cycle(); drive(0, 0, 1, k, XLEN'(k), 0);
        end
        next_cycle(); drive(1, 25, 1, 25, 32'hFFFFFFFF, 0); set_rs(25, 0, 0, 0);
        at_neg(); check("addr25 read", 64'(rs_rdata[0 +: XLEN]), 64'h0); check("addr25 ready", 64'(issue_ready), 64'h1);
        next_cycle(); drive(0, 0, 0, 0, '0, 0); set_rs(1, 2, 3, 4);
        at_neg(); check("addr25 count", 64'(busy_count), 64'h0);
        for (int p = 0; p < RP; p++) begin
            check($sformatf("port%0d x%0d", p, p + 1), 64'(rs_rdata[p*XLEN +: XLEN]), 64'(p + 1));
        end

        // Random traffic, occasional flush and mid-run reset
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            rst_n = ($urandom_range(0, 299) != 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, NSLOT - 1),
                  $urandom_range(0, 9) < 6, $urandom_range(0, NSLOT - 1),
                  $urandom, $urandom_range(0, 15) == 0);
            set_rs($urandom_range(0, NSLOT - 1), $urandom_range(0, NSLOT - 1),
                   $urandom_range(0, NSLOT - 1), $urandom_range(0, NSLOT - 1));
            if ($urandom_range(0, 3) == 0) rs_addr[0 +: AW] = wb_addr;
            if ($urandom_range(0, 3) == 0) issue_addr = rs_addr[AW +: AW];
        end
        next_cycle();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, '0, 0);
        at_neg();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
